reorder_tag_scheduler: RTL and testbench

//  Issue-side scheduler for the reorder queue: round-robin arbitrates NUM_REQ requesters for bus transaction tags.

---
 rtl/reorder_sched_pkg.sv | 38 +++
 rtl/reorder_tag_scheduler_rr_arbiter.sv | 55 +++++
 rtl/reorder_tag_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_reorder_tag_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_sched_pkg.sv
// Shared types and defaults for the reorder-queue issue scheduler.
//   sched_state_e : issue FSM states (IDLE -> ENQ -> ISSUE)
//   tag_state_e   : lifecycle of one transaction tag (free, pending, issued)
//   tag_state()   : folds the busy/issued bit pair of a tag into tag_state_e
package reorder_sched_pkg;

  localparam int NUM_REQ_DEF  = 2;
  localparam int NUM_TAGS_DEF = 4;
  localparam int TAG_W_DEF    = 2;
  localparam int SRC_W_DEF    = 1;
  localparam int BEAT_W_DEF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENQ   = 2'd1,
    ISSUE = 2'd2
  } sched_state_e;

  typedef enum logic [1:0] {
    TAG_FREE    = 2'd0,
    TAG_PENDING = 2'd1,
    TAG_ISSUED  = 2'd2
  } tag_state_e;

  // A tag is pending while its request sits in ENQ/ISSUE, issued once downstream accepted it.
  function automatic tag_state_e tag_state(input logic busy, input logic issued);
    tag_state_e st;
    if (!busy) begin
      st = TAG_FREE;
    end else if (issued) begin
      st = TAG_ISSUED;
    end else begin
      st = TAG_PENDING;
    end
    return st;
  endfunction

endpackage

// File: rtl/reorder_tag_scheduler_rr_arbiter.sv
// Round-robin arbiter.
//   req   : request vector          en    : arbitration allowed this cycle
//   grant : one-hot grant           idx   : index of the granted requester
//   valid : a grant was made; the priority pointer then moves past the winner
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int SRC_W   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [SRC_W-1:0]   idx,
  output logic               valid
);

  logic [SRC_W-1:0]   ptr_r;
  logic [SRC_W-1:0]   cand_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [SRC_W-1:0]   idx_s;
  logic               found_s;

  // Scan requesters starting at the pointer; first active one wins.
  always_comb begin
    grant_s = '0;
    idx_s   = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = SRC_W'((int'(ptr_r) + k) % NUM_REQ);
      if (en && !found_s && req[cand_s]) begin
        grant_s[cand_s] = 1'b1;
        idx_s           = cand_s;
        found_s         = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Priority pointer: one past the last winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (found_s) begin
      ptr_r <= SRC_W'((int'(idx_s) + 1) % NUM_REQ);
    end
  end

  assign grant = grant_s;
  assign idx   = idx_s;
  assign valid = found_s;

endmodule

// File: rtl/reorder_tag_scheduler.sv
// Issue-side scheduler for the reorder queue.
// Arbitrates requesters round-robin, allocates the lowest free tag, writes the
// request into the reorder queue (rq_enq_*), issues it downstream (issue_*),
// and retires the tag through rq_deq_* when the last response beat returns,
// reporting completion on done_* one cycle later.
//   req_*      : requester side (req_ready is a combinational one-hot grant)
//   rq_enq_*   : queue write port        issue_*   : downstream request
//   resp_*     : downstream response     rq_deq_*  : queue retire port
//   done_*     : registered completion   err_unmatched : bad response tag
//   outstanding: registered count of busy tags
module reorder_tag_scheduler
  import reorder_sched_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int NUM_TAGS = NUM_TAGS_DEF,
  parameter int TAG_W    = TAG_W_DEF,
  parameter int SRC_W    = SRC_W_DEF,
  parameter int BEAT_W   = BEAT_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*BEAT_W-1:0] req_addr_beat,
  input  logic [NUM_REQ-1:0]        req_subblock,
  output logic                      rq_enq_valid,
  input  logic                      rq_enq_ready,
  output logic [BEAT_W-1:0]         rq_enq_addr_beat,
  output logic                      rq_enq_subblock,
  output logic [TAG_W-1:0]          rq_enq_tag,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [TAG_W-1:0]          issue_tag,
  output logic [SRC_W-1:0]          issue_src,
  input  logic                      resp_valid,
  input  logic                      resp_last,
  input  logic [TAG_W-1:0]          resp_tag,
  output logic                      rq_deq_valid,
  output logic [TAG_W-1:0]          rq_deq_tag,
  input  logic [BEAT_W-1:0]         rq_deq_addr_beat,
  input  logic                      rq_deq_subblock,
  input  logic                      rq_deq_matches,
  output logic                      done_valid,
  output logic [SRC_W-1:0]          done_src,
  output logic [BEAT_W-1:0]         done_addr_beat,
  output logic                      done_subblock,
  output logic [TAG_W-1:0]          done_tag,
  output logic                      err_unmatched,
  output logic [TAG_W:0]            outstanding
);

  localparam int CNT_W = TAG_W + 1;

  sched_state_e         state_r, state_next_s;
  logic [SRC_W-1:0]     cur_src_r;
  logic [BEAT_W-1:0]    cur_beat_r;
  logic                 cur_sub_r;
  logic [TAG_W-1:0]     cur_tag_r;
  logic [NUM_TAGS-1:0]  busy_r, busy_next_s;
  logic [NUM_TAGS-1:0]  issued_r, issued_next_s;
  logic [SRC_W-1:0]     src_tab_r [NUM_TAGS];
  logic [TAG_W-1:0]     free_tag_s;
  logic                 any_free_s;
  logic                 grant_en_s, grant_fire_s, issue_fire_s;
  logic [NUM_REQ-1:0]   grant_s;
  logic [SRC_W-1:0]     win_s;
  logic                 resp_end_s, retire_s, bad_resp_s;
  logic [CNT_W-1:0]     busy_cnt_s;
  logic                 done_valid_r, done_sub_r, err_r;
  logic [SRC_W-1:0]     done_src_r;
  logic [BEAT_W-1:0]    done_beat_r;
  logic [TAG_W-1:0]     done_tag_r;
  logic [CNT_W-1:0]     outstanding_r;

  // Lowest-index free tag (descending scan so the lowest hit is kept).
  always_comb begin
    free_tag_s = '0;
    any_free_s = 1'b0;
    for (int t = NUM_TAGS - 1; t >= 0; t--) begin
      if (!busy_r[t]) begin
        free_tag_s = TAG_W'(t);
        any_free_s = 1'b1;
      end else begin
        any_free_s = any_free_s;
      end
    end
  end

  // Grants only in IDLE with a free tag; reset masks the combinational grant.
  assign grant_en_s = (state_r == IDLE) && any_free_s && !reset;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .SRC_W(SRC_W)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .en    (grant_en_s),
    .grant (grant_s),
    .idx   (win_s),
    .valid (grant_fire_s)
  );

  assign req_ready = grant_s;

  // Issue FSM next state and handshake outputs.
  always_comb begin
    state_next_s = state_r;
    rq_enq_valid = 1'b0;
    issue_valid  = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_fire_s) state_next_s = ENQ;
        else              state_next_s = IDLE;
      end
      ENQ: begin
        rq_enq_valid = 1'b1;
        if (rq_enq_ready) state_next_s = ISSUE;
        else              state_next_s = ENQ;
      end
      ISSUE: begin
        issue_valid = 1'b1;
        if (issue_ready) state_next_s = IDLE;
        else             state_next_s = ISSUE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  assign issue_fire_s = issue_valid && issue_ready;

  // Only a last beat for an issued tag retires it; anything else is an error.
  assign resp_end_s   = resp_valid && resp_last;
  assign rq_deq_valid = resp_end_s && (tag_state(busy_r[resp_tag], issued_r[resp_tag]) == TAG_ISSUED);
  assign rq_deq_tag   = resp_tag;
  assign retire_s     = rq_deq_valid && rq_deq_matches;
  assign bad_resp_s   = resp_end_s && !retire_s;

  // Tag vector updates; retire and grant never touch the same tag.
  always_comb begin
    busy_next_s   = busy_r;
    issued_next_s = issued_r;
    if (retire_s) begin
      busy_next_s[resp_tag]   = 1'b0;
      issued_next_s[resp_tag] = 1'b0;
    end else begin
      busy_next_s = busy_next_s;
    end
    if (grant_fire_s) begin
      busy_next_s[free_tag_s] = 1'b1;
    end else begin
      busy_next_s = busy_next_s;
    end
    if (issue_fire_s) begin
      issued_next_s[cur_tag_r] = 1'b1;
    end else begin
      issued_next_s = issued_next_s;
    end
  end

  // Popcount of the next busy vector so outstanding tracks busy_r exactly.
  always_comb begin
    busy_cnt_s = '0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      busy_cnt_s = busy_cnt_s + CNT_W'(busy_next_s[t]);
    end
  end

  // FSM, tag state, latched request and per-tag source table.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      busy_r        <= '0;
      issued_r      <= '0;
      outstanding_r <= '0;
      cur_src_r     <= '0;
      cur_beat_r    <= '0;
      cur_sub_r     <= 1'b0;
      cur_tag_r     <= '0;
      for (int t = 0; t < NUM_TAGS; t++) src_tab_r[t] <= '0;
    end else begin
      state_r       <= state_next_s;
      busy_r        <= busy_next_s;
      issued_r      <= issued_next_s;
      outstanding_r <= busy_cnt_s;
      if (grant_fire_s) begin
        cur_src_r             <= win_s;
        cur_beat_r            <= req_addr_beat[int'(win_s) * BEAT_W +: BEAT_W];
        cur_sub_r             <= req_subblock[win_s];
        cur_tag_r             <= free_tag_s;
        src_tab_r[free_tag_s] <= win_s;
      end
    end
  end

  // Completion and error pulses, one cycle after the response beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_valid_r <= 1'b0;
      done_src_r   <= '0;
      done_beat_r  <= '0;
      done_sub_r   <= 1'b0;
      done_tag_r   <= '0;
      err_r        <= 1'b0;
    end else begin
      done_valid_r <= retire_s;
      err_r        <= bad_resp_s;
      if (retire_s) begin
        done_src_r  <= src_tab_r[resp_tag];
        done_beat_r <= rq_deq_addr_beat;
        done_sub_r  <= rq_deq_subblock;
        done_tag_r  <= resp_tag;
      end
    end
  end

  assign rq_enq_addr_beat = cur_beat_r;
  assign rq_enq_subblock  = cur_sub_r;
  assign rq_enq_tag       = cur_tag_r;
  assign issue_tag        = cur_tag_r;
  assign issue_src        = cur_src_r;
  assign done_valid       = done_valid_r;
  assign done_src         = done_src_r;
  assign done_addr_beat   = done_beat_r;
  assign done_subblock    = done_sub_r;
  assign done_tag         = done_tag_r;
  assign err_unmatched    = err_r;
  assign outstanding      = outstanding_r;

endmodule

// File: tb/tb_reorder_tag_scheduler.sv
// Self-checking bench for reorder_tag_scheduler: directed sequences push the
// expected queue writes, issues and completions into scoreboards; a negedge
// monitor pops and compares whenever the DUT produces them. A small reorder
// queue model answers the deq port.
module tb_reorder_tag_scheduler;

  localparam int NUM_REQ = 2, NUM_TAGS = 4, TAG_W = 2, SRC_W = 1, BEAT_W = 3;

  logic clk = 1'b0;
  logic reset;
  logic [NUM_REQ-1:0]        req_valid, req_ready, req_subblock;
  logic [NUM_REQ*BEAT_W-1:0] req_addr_beat;
  logic                      rq_enq_valid, rq_enq_ready, rq_enq_subblock;
  logic [BEAT_W-1:0]         rq_enq_addr_beat;
  logic [TAG_W-1:0]          rq_enq_tag, issue_tag, resp_tag, rq_deq_tag, done_tag;
  logic                      issue_valid, issue_ready, resp_valid, resp_last;
  logic [SRC_W-1:0]          issue_src, done_src;
  logic                      rq_deq_valid, rq_deq_subblock, rq_deq_matches;
  logic [BEAT_W-1:0]         rq_deq_addr_beat, done_addr_beat;
  logic                      done_valid, done_subblock, err_unmatched;
  logic [TAG_W:0]            outstanding;

  logic [BEAT_W-1:0] beat0_v, beat1_v;
  assign req_addr_beat = {beat1_v, beat0_v};

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_enq_q[$];
  logic [15:0] exp_iss_q[$];
  logic [15:0] exp_done_q[$];

  logic [BEAT_W-1:0] qm_beat [NUM_TAGS];
  logic              qm_sub  [NUM_TAGS];
  logic              qm_vld  [NUM_TAGS];

  assign rq_deq_addr_beat = qm_beat[rq_deq_tag];
  assign rq_deq_subblock  = qm_sub[rq_deq_tag];
  assign rq_deq_matches   = qm_vld[rq_deq_tag];

  reorder_tag_scheduler dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr_beat(req_addr_beat), .req_subblock(req_subblock),
    .rq_enq_valid(rq_enq_valid), .rq_enq_ready(rq_enq_ready),
    .rq_enq_addr_beat(rq_enq_addr_beat), .rq_enq_subblock(rq_enq_subblock),
    .rq_enq_tag(rq_enq_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_tag(issue_tag), .issue_src(issue_src),
    .resp_valid(resp_valid), .resp_last(resp_last), .resp_tag(resp_tag),
    .rq_deq_valid(rq_deq_valid), .rq_deq_tag(rq_deq_tag),
    .rq_deq_addr_beat(rq_deq_addr_beat), .rq_deq_subblock(rq_deq_subblock),
    .rq_deq_matches(rq_deq_matches),
    .done_valid(done_valid), .done_src(done_src), .done_addr_beat(done_addr_beat),
    .done_subblock(done_subblock), .done_tag(done_tag),
    .err_unmatched(err_unmatched), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] pk_enq(input logic [1:0] t, input logic [2:0] b, input logic s);
    return {10'd0, t, b, s};
  endfunction

  function automatic logic [15:0] pk_iss(input logic [1:0] t, input logic src);
    return {13'd0, t, src};
  endfunction

  function automatic logic [15:0] pk_done(input logic src, input logic [2:0] b, input logic s, input logic [1:0] t);
    return {9'd0, src, b, s, t};
  endfunction

  // Reorder queue model: slot written on enq handshake, cleared on deq strobe.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        qm_vld[i]  <= 1'b0;
        qm_beat[i] <= 3'd0;
        qm_sub[i]  <= 1'b0;
      end
    end else begin
      if (rq_enq_valid && rq_enq_ready) begin
        qm_vld[rq_enq_tag]  <= 1'b1;
        qm_beat[rq_enq_tag] <= rq_enq_addr_beat;
        qm_sub[rq_enq_tag]  <= rq_enq_subblock;
      end
      if (rq_deq_valid) qm_vld[rq_deq_tag] <= 1'b0;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (rq_enq_valid && rq_enq_ready) begin
        if (exp_enq_q.size() == 0) chk("enq_unexpected", 32'(exp_enq_q.size()), 32'd1);
        else chk("enq", 32'(pk_enq(rq_enq_tag, rq_enq_addr_beat, rq_enq_subblock)), 32'(exp_enq_q.pop_front()));
      end
      if (issue_valid && issue_ready) begin
        if (exp_iss_q.size() == 0) chk("issue_unexpected", 32'(exp_iss_q.size()), 32'd1);
        else chk("issue", 32'(pk_iss(issue_tag, issue_src)), 32'(exp_iss_q.pop_front()));
      end
      if (done_valid) begin
        if (exp_done_q.size() == 0) chk("done_unexpected", 32'(exp_done_q.size()), 32'd1);
        else chk("done", 32'(pk_done(done_src, done_addr_beat, done_subblock, done_tag)), 32'(exp_done_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_check(input string name);
    chk({name, "_enq_left"},  32'(exp_enq_q.size()),  32'd0);
    chk({name, "_iss_left"},  32'(exp_iss_q.size()),  32'd0);
    chk({name, "_done_left"}, 32'(exp_done_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b00; req_subblock = 2'b00; beat0_v = 3'd0; beat1_v = 3'd0;
    rq_enq_ready = 1'b1; issue_ready = 1'b1;
    resp_valid = 1'b0; resp_last = 1'b0; resp_tag = 2'd0;
    exp_enq_q.delete(); exp_iss_q.delete(); exp_done_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic resp(input logic v, input logic l, input logic [1:0] t);
    resp_valid = v; resp_last = l; resp_tag = t;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    // Test 1: single request, full round trip.
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_done", 32'(done_valid), 32'd0);
    beat0_v = 3'd5; req_valid = 2'b01;
    exp_enq_q.push_back(pk_enq(2'd0, 3'd5, 1'b0)); exp_iss_q.push_back(pk_iss(2'd0, 1'b0));
    #1 chk("t1_ready", 32'(req_ready), 32'd1);
    step(); req_valid = 2'b00;
    #1 chk("t1_enq_valid", 32'(rq_enq_valid), 32'd1); chk("t1_enq_tag", 32'(rq_enq_tag), 32'd0);
    step();
    #1 chk("t1_issue_valid", 32'(issue_valid), 32'd1); chk("t1_issue_src", 32'(issue_src), 32'd0);
    step();
    #1 chk("t1_outstanding", 32'(outstanding), 32'd1);
    resp(1'b1, 1'b1, 2'd0); exp_done_q.push_back(pk_done(1'b0, 3'd5, 1'b0, 2'd0));
    #1 chk("t1_deq_valid", 32'(rq_deq_valid), 32'd1);
    step(); resp(1'b0, 1'b0, 2'd0);
    #1 chk("t1_done_valid", 32'(done_valid), 32'd1); chk("t1_done_beat", 32'(done_addr_beat), 32'd5);
    chk("t1_out_after", 32'(outstanding), 32'd0);
    step(); step(); drain_check("t1");

    // Test 2: both requesting, round-robin over four tags then stall.
    do_reset();
    beat0_v = 3'd3; beat1_v = 3'd6; req_subblock = 2'b10; req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      logic src;
      src = 1'(i % 2);
      exp_enq_q.push_back(pk_enq(2'(i), src ? 3'd6 : 3'd3, src));
      exp_iss_q.push_back(pk_iss(2'(i), src));
    end
    repeat (12) step();
    #1 chk("t2_stall_ready", 32'(req_ready), 32'd0); chk("t2_outstanding", 32'(outstanding), 32'd4);
    step();
    #1 chk("t2_stall_ready2", 32'(req_ready), 32'd0); chk("t2_no_issue", 32'(issue_valid), 32'd0);
    drain_check("t2");

    // Test 3: free tag2 while full; it is regranted the following cycle.
    resp(1'b1, 1'b1, 2'd2);
    exp_done_q.push_back(pk_done(1'b0, 3'd3, 1'b0, 2'd2));
    exp_enq_q.push_back(pk_enq(2'd2, 3'd3, 1'b0)); exp_iss_q.push_back(pk_iss(2'd2, 1'b0));
    #1 chk("t3_deq_valid", 32'(rq_deq_valid), 32'd1); chk("t3_deq_tag", 32'(rq_deq_tag), 32'd2);
    chk("t3_no_same_cycle_grant", 32'(req_ready), 32'd0);
    step(); resp(1'b0, 1'b0, 2'd0);
    #1 chk("t3_out3", 32'(outstanding), 32'd3); chk("t3_ready", 32'(req_ready), 32'd1);
    step();
    #1 chk("t3_out4", 32'(outstanding), 32'd4); req_valid = 2'b00;
    repeat (3) step();
    drain_check("t3");

    // Test 4: downstream backpressure holds the issue stable.
    resp(1'b1, 1'b1, 2'd0);
    exp_done_q.push_back(pk_done(1'b0, 3'd3, 1'b0, 2'd0));
    step(); resp(1'b0, 1'b0, 2'd0);
    req_valid = 2'b10; issue_ready = 1'b0;
    exp_enq_q.push_back(pk_enq(2'd0, 3'd6, 1'b1)); exp_iss_q.push_back(pk_iss(2'd0, 1'b1));
    #1 chk("t4_ready", 32'(req_ready), 32'd2);
    step(); step();
    for (int i = 0; i < 10; i++) begin
      #1 chk("t4_hold_valid", 32'(issue_valid), 32'd1);
      chk("t4_hold_tag", 32'(issue_tag), 32'd0);
      chk("t4_hold_ready", 32'(req_ready), 32'd0);
      step();
    end
    issue_ready = 1'b1; req_valid = 2'b00;
    step(); step();
    drain_check("t4");

    // Test 5: responses for a free tag, a pending tag and a non-last beat.
    resp(1'b1, 1'b1, 2'd1);
    exp_done_q.push_back(pk_done(1'b1, 3'd6, 1'b1, 2'd1));
    #1 chk("t5_deq_ok", 32'(rq_deq_valid), 32'd1);
    step();
    #1 chk("t5_free_no_deq", 32'(rq_deq_valid), 32'd0);
    step(); resp(1'b0, 1'b0, 2'd0);
    #1 chk("t5_err_free", 32'(err_unmatched), 32'd1); chk("t5_out_free", 32'(outstanding), 32'd3);
    resp(1'b1, 1'b0, 2'd3);
    #1 chk("t5_nonlast_no_deq", 32'(rq_deq_valid), 32'd0);
    step(); resp(1'b0, 1'b0, 2'd0);
    #1 chk("t5_nonlast_no_err", 32'(err_unmatched), 32'd0);
    req_valid = 2'b01; issue_ready = 1'b0;
    exp_enq_q.push_back(pk_enq(2'd1, 3'd3, 1'b0)); exp_iss_q.push_back(pk_iss(2'd1, 1'b0));
    step(); req_valid = 2'b00;
    step();
    resp(1'b1, 1'b1, 2'd1);
    #1 chk("t5_pending_no_deq", 32'(rq_deq_valid), 32'd0);
    step(); resp(1'b0, 1'b0, 2'd0);
    #1 chk("t5_err_pending", 32'(err_unmatched), 32'd1); chk("t5_out_pending", 32'(outstanding), 32'd4);
    chk("t5_still_issue", 32'(issue_valid), 32'd1);
    step();
    #1 chk("t5_err_clear", 32'(err_unmatched), 32'd0);
    issue_ready = 1'b1;
    step(); step();
    drain_check("t5");

    // Test 6: reset in ENQ with two tags issued.
    do_reset();
    beat0_v = 3'd3; beat1_v = 3'd6; req_subblock = 2'b10; req_valid = 2'b11;
    exp_enq_q.push_back(pk_enq(2'd0, 3'd3, 1'b0)); exp_iss_q.push_back(pk_iss(2'd0, 1'b0));
    exp_enq_q.push_back(pk_enq(2'd1, 3'd6, 1'b1)); exp_iss_q.push_back(pk_iss(2'd1, 1'b1));
    repeat (6) step();
    rq_enq_ready = 1'b0;
    step();
    #1 chk("t6_in_enq", 32'(rq_enq_valid), 32'd1); chk("t6_out3", 32'(outstanding), 32'd3);
    drain_check("t6a");
    reset = 1'b1;
    #1 chk("t6_rst_ready", 32'(req_ready), 32'd0); chk("t6_rst_enq", 32'(rq_enq_valid), 32'd0);
    chk("t6_rst_issue", 32'(issue_valid), 32'd0); chk("t6_rst_out", 32'(outstanding), 32'd0);
    chk("t6_rst_done", 32'(done_valid), 32'd0); chk("t6_rst_err", 32'(err_unmatched), 32'd0);
    do_reset();
    beat0_v = 3'd2; req_valid = 2'b01;
    exp_enq_q.push_back(pk_enq(2'd0, 3'd2, 1'b0)); exp_iss_q.push_back(pk_iss(2'd0, 1'b0));
    #1 chk("t6_out0", 32'(outstanding), 32'd0); chk("t6_ready", 32'(req_ready), 32'd1);
    step(); req_valid = 2'b00;
    repeat (3) step();
    drain_check("t6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
